// File: rtl/pong_pkg.sv
// Shared playfield geometry, FSM encoding and direction constants for the pong datapath.
package pong_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  localparam int unsigned X_W   = 10;
  localparam int unsigned Y_W   = 9;
  localparam int unsigned DIM_W = 6;
  localparam int unsigned LEN_W = 9;
  localparam int unsigned DY_W  = 2;
  // Signed working width for next-position math; wide enough that no sum wraps.
  localparam int unsigned S_W   = 12;

  typedef enum logic [1:0] {
    SERVE  = 2'd0,
    PLAY   = 2'd1,
    SCORED = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  localparam logic VDIR_UP   = 1'b1;
  localparam logic VDIR_DOWN = 1'b0;

endpackage

// File: rtl/paddle_hit.sv
// Vertical overlap test between ball and one paddle, plus the spin the paddle imparts.
module paddle_hit
  import pong_pkg::*;
(
  input  logic [Y_W-1:0]   i_ball_y,
  input  logic [DIM_W-1:0] i_ball_width,
  input  logic [Y_W-1:0]   i_paddle_y,
  input  logic [LEN_W-1:0] i_paddle_length,
  output logic             o_overlap_c,
  output logic [DY_W-1:0]  o_dy_c,
  output logic             o_vdir_c
);

  logic [S_W-1:0]        w_ball_bot;
  logic [S_W-1:0]        w_pad_bot;
  logic signed [S_W-1:0] w_off;
  logic signed [S_W-1:0] w_quarter;
  logic signed [S_W-1:0] w_half;
  logic signed [S_W-1:0] w_outer;

  assign w_ball_bot = S_W'(i_ball_y) + S_W'(i_ball_width);
  assign w_pad_bot  = S_W'(i_paddle_y) + S_W'(i_paddle_length);

  // Offset of the ball centre below the paddle top; negative when the centre is above it.
  assign w_off     = $signed(S_W'(i_ball_y) + S_W'(i_ball_width[DIM_W-1:1]) - S_W'(i_paddle_y));
  assign w_quarter = $signed(S_W'(i_paddle_length[LEN_W-1:2]));
  assign w_half    = $signed(S_W'(i_paddle_length[LEN_W-1:1]));
  assign w_outer   = $signed(S_W'(i_paddle_length) - S_W'(i_paddle_length[LEN_W-1:2]));

  // Overlap on current position; outer quarters give steep spin, upper half sends the ball up.
  always_comb begin
    o_overlap_c = (w_ball_bot > S_W'(i_paddle_y)) && (S_W'(i_ball_y) < w_pad_bot);
    o_dy_c      = ((w_off < w_quarter) || (w_off >= w_outer)) ? DY_W'(3) : DY_W'(1);
    o_vdir_c    = (w_off < w_half) ? VDIR_UP : VDIR_DOWN;
  end

endmodule

// File: rtl/ball_motion.sv
// Ball position/heading generator: serve delay, per-clock motion, wall and paddle bounces, miss scoring.
module ball_motion
  import pong_pkg::*;
#(
  parameter int unsigned DX          = 4,
  parameter int unsigned SERVE_DELAY = 60
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [DIM_W-1:0] wall_width,
  input  logic [DIM_W-1:0] ball_width,
  input  logic [DIM_W-1:0] paddle_width,
  input  logic [LEN_W-1:0] paddle_length,
  input  logic [X_W-1:0]   left_x,
  input  logic [Y_W-1:0]   left_y,
  input  logic [X_W-1:0]   right_x,
  input  logic [Y_W-1:0]   right_y,
  output logic [X_W-1:0]   ball_x,
  output logic [Y_W-1:0]   ball_y,
  output logic             ball_direction,
  output logic             in_play,
  output logic             score_left,
  output logic             score_right
);

  localparam int unsigned CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

  state_t            r_state, w_state_nxt;
  logic [X_W-1:0]    r_ball_x, w_x_nxt;
  logic [Y_W-1:0]    r_ball_y, w_y_nxt;
  logic              r_dir, w_dir_nxt;
  logic              r_vdir, w_vdir_nxt;
  logic [DY_W-1:0]   r_dy, w_dy_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_in_play, w_in_play_nxt;
  logic              r_score_l, w_score_l_nxt;
  logic              r_score_r, w_score_r_nxt;

  logic [X_W-1:0]        w_ctr_x;
  logic [Y_W-1:0]        w_ctr_y;
  logic signed [S_W-1:0] w_x, w_y, w_dy, w_nx, w_ny;
  logic signed [S_W-1:0] w_bw, w_wall, w_pw, w_lx, w_rx, w_floor, w_scr_w;
  logic                  w_l_ovl, w_r_ovl, w_l_vdir, w_r_vdir;
  logic [DY_W-1:0]       w_l_dy, w_r_dy;
  logic                  w_lhit, w_rhit, w_lmiss, w_rmiss;

  assign w_ctr_x = X_W'((S_W'(SCREEN_W) - S_W'(ball_width)) >> 1);
  assign w_ctr_y = Y_W'((S_W'(SCREEN_H) - S_W'(ball_width)) >> 1);

  assign w_x     = $signed(S_W'(r_ball_x));
  assign w_y     = $signed(S_W'(r_ball_y));
  assign w_dy    = $signed(S_W'(r_dy));
  assign w_bw    = $signed(S_W'(ball_width));
  assign w_wall  = $signed(S_W'(wall_width));
  assign w_pw    = $signed(S_W'(paddle_width));
  assign w_lx    = $signed(S_W'(left_x));
  assign w_rx    = $signed(S_W'(right_x));
  assign w_scr_w = $signed(S_W'(SCREEN_W));
  assign w_floor = $signed(S_W'(SCREEN_H)) - w_wall - w_bw;

  assign w_nx = (r_dir == DIR_LEFT) ? (w_x - $signed(S_W'(DX))) : (w_x + $signed(S_W'(DX)));
  assign w_ny = (r_vdir == VDIR_UP) ? (w_y - w_dy) : (w_y + w_dy);

  paddle_hit u_left_hit (
    .i_ball_y        (r_ball_y),
    .i_ball_width    (ball_width),
    .i_paddle_y      (left_y),
    .i_paddle_length (paddle_length),
    .o_overlap_c     (w_l_ovl),
    .o_dy_c          (w_l_dy),
    .o_vdir_c        (w_l_vdir)
  );

  paddle_hit u_right_hit (
    .i_ball_y        (r_ball_y),
    .i_ball_width    (ball_width),
    .i_paddle_y      (right_y),
    .i_paddle_length (paddle_length),
    .o_overlap_c     (w_r_ovl),
    .o_dy_c          (w_r_dy),
    .o_vdir_c        (w_r_vdir)
  );

  assign w_lhit  = (r_dir == DIR_LEFT)  && (w_nx <= (w_lx + w_pw)) && w_l_ovl;
  assign w_rhit  = (r_dir == DIR_RIGHT) && ((w_nx + w_bw) >= w_rx) && w_r_ovl;
  assign w_lmiss = (r_dir == DIR_LEFT)  && !w_lhit && w_nx[S_W-1];
  assign w_rmiss = (r_dir == DIR_RIGHT) && !w_rhit && ((w_nx + w_bw) > w_scr_w);

  // Next-state and next-output logic; everything holds unless enable is high.
  always_comb begin
    w_state_nxt   = r_state;
    w_x_nxt       = r_ball_x;
    w_y_nxt       = r_ball_y;
    w_dir_nxt     = r_dir;
    w_vdir_nxt    = r_vdir;
    w_dy_nxt      = r_dy;
    w_cnt_nxt     = r_cnt;
    w_score_l_nxt = r_score_l;
    w_score_r_nxt = r_score_r;
    w_in_play_nxt = r_in_play;

    if (enable) begin
      w_score_l_nxt = 1'b0;
      w_score_r_nxt = 1'b0;
      unique case (r_state)
        SERVE: begin
          w_dy_nxt = DY_W'(1);
          if (r_cnt == CNT_W'(SERVE_DELAY - 1)) begin
            w_state_nxt = PLAY;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        PLAY: begin
          if ((r_vdir == VDIR_UP) && (w_ny < w_wall)) begin
            w_y_nxt    = Y_W'(w_wall);
            w_vdir_nxt = VDIR_DOWN;
          end else if (w_ny > w_floor) begin
            w_y_nxt    = Y_W'(w_floor);
            w_vdir_nxt = VDIR_UP;
          end else begin
            w_y_nxt = Y_W'(w_ny);
          end

          if (w_lhit) begin
            w_x_nxt    = X_W'(w_lx + w_pw);
            w_dir_nxt  = DIR_RIGHT;
            w_dy_nxt   = w_l_dy;
            w_vdir_nxt = w_l_vdir;
          end else if (w_rhit) begin
            w_x_nxt    = X_W'(w_rx - w_bw);
            w_dir_nxt  = DIR_LEFT;
            w_dy_nxt   = w_r_dy;
            w_vdir_nxt = w_r_vdir;
          end else if (w_lmiss) begin
            w_x_nxt       = '0;
            w_dir_nxt     = DIR_LEFT;
            w_score_r_nxt = 1'b1;
            w_state_nxt   = SCORED;
          end else if (w_rmiss) begin
            w_x_nxt       = X_W'(w_scr_w - w_bw);
            w_dir_nxt     = DIR_RIGHT;
            w_score_l_nxt = 1'b1;
            w_state_nxt   = SCORED;
          end else begin
            w_x_nxt = X_W'(w_nx);
          end
        end
        SCORED: begin
          w_x_nxt     = w_ctr_x;
          w_y_nxt     = w_ctr_y;
          w_dy_nxt    = DY_W'(1);
          w_cnt_nxt   = '0;
          w_state_nxt = SERVE;
        end
        default: begin
          w_state_nxt = SERVE;
          w_cnt_nxt   = '0;
        end
      endcase
      w_in_play_nxt = (w_state_nxt == PLAY);
    end
  end

  // State and output registers; reset recentres the ball and drops any pending score pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= SERVE;
      r_ball_x  <= w_ctr_x;
      r_ball_y  <= w_ctr_y;
      r_dir     <= DIR_LEFT;
      r_vdir    <= VDIR_DOWN;
      r_dy      <= DY_W'(1);
      r_cnt     <= '0;
      r_in_play <= 1'b0;
      r_score_l <= 1'b0;
      r_score_r <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ball_x  <= w_x_nxt;
      r_ball_y  <= w_y_nxt;
      r_dir     <= w_dir_nxt;
      r_vdir    <= w_vdir_nxt;
      r_dy      <= w_dy_nxt;
      r_cnt     <= w_cnt_nxt;
      r_in_play <= w_in_play_nxt;
      r_score_l <= w_score_l_nxt;
      r_score_r <= w_score_r_nxt;
    end
  end

  assign ball_x         = r_ball_x;
  assign ball_y         = r_ball_y;
  assign ball_direction = r_dir;
  assign in_play        = r_in_play;
  assign score_left     = r_score_l;
  assign score_right    = r_score_r;

endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: game-rule model checked every cycle plus hand-computed pins along one rally script.
module tb_ball_motion;

  localparam int MDX = 4;
  localparam int MSD = 60;
  localparam int SW  = 640;
  localparam int SH  = 480;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [5:0] wall_width = 6'd10;
  logic [5:0] ball_width = 6'd6;
  logic [5:0] paddle_width = 6'd10;
  logic [8:0] paddle_length = 9'd80;
  logic [9:0] left_x = 10'd0;
  logic [8:0] left_y = 9'd276;
  logic [9:0] right_x = 10'd630;
  logic [8:0] right_y = 9'd460;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic       ball_direction, in_play, score_left, score_right;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Model state: phase 0 = serving, 1 = rally, 2 = point just scored. vd 1 = moving up.
  int m_x = 317, m_y = 237, m_dir = 1, m_vd = 0, m_dy = 1, m_ph = 0, m_cnt = 0;
  int m_sl = 0, m_sr = 0, m_ip = 0;

  ball_motion #(.DX(4), .SERVE_DELAY(60)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .wall_width(wall_width), .ball_width(ball_width),
    .paddle_width(paddle_width), .paddle_length(paddle_length),
    .left_x(left_x), .left_y(left_y), .right_x(right_x), .right_y(right_y),
    .ball_x(ball_x), .ball_y(ball_y), .ball_direction(ball_direction),
    .in_play(in_play), .score_left(score_left), .score_right(score_right)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit ovl(input int y, input int bw, input int py, input int pl);
    return (y + bw > py) && (y < py + pl);
  endfunction

  // Centre offset from paddle top decides steepness (outer quarters steep) and heading.
  function automatic int spin_dy(input int y, input int bw, input int py, input int pl);
    int off = y + bw / 2 - py;
    return (off < pl / 4 || off >= pl - pl / 4) ? 3 : 1;
  endfunction

  function automatic int spin_up(input int y, input int bw, input int py, input int pl);
    int off = y + bw / 2 - py;
    return (off < pl / 2) ? 1 : 0;
  endfunction

  // Game-rule model, advanced once per enabled clock.
  always @(posedge clk or posedge reset) begin : model
    int x, y, dir, vd, dy, ph, cnt, sl, sr, nx, ny, bw, wall, pl, pw, lx, ly, rx, ry;
    bit lh, rh;
    if (reset) begin
      m_x <= (SW - int'(ball_width)) / 2; m_y <= (SH - int'(ball_width)) / 2;
      m_dir <= 1; m_vd <= 0; m_dy <= 1; m_ph <= 0; m_cnt <= 0;
      m_sl <= 0; m_sr <= 0; m_ip <= 0;
    end else if (enable) begin
      x = m_x; y = m_y; dir = m_dir; vd = m_vd; dy = m_dy; ph = m_ph; cnt = m_cnt;
      sl = 0; sr = 0;
      bw = int'(ball_width); wall = int'(wall_width); pl = int'(paddle_length);
      pw = int'(paddle_width); lx = int'(left_x); ly = int'(left_y);
      rx = int'(right_x); ry = int'(right_y);
      if (m_ph == 0) begin
        dy = 1;
        if (m_cnt == MSD - 1) begin ph = 1; cnt = 0; end
        else cnt = m_cnt + 1;
      end else if (m_ph == 1) begin
        nx = (m_dir == 1) ? m_x - MDX : m_x + MDX;
        ny = (m_vd == 1) ? m_y - m_dy : m_y + m_dy;
        if (m_vd == 1 && ny < wall) begin y = wall; vd = 0; end
        else if (ny + bw > SH - wall) begin y = SH - wall - bw; vd = 1; end
        else y = ny;
        lh = (m_dir == 1) && (nx <= lx + pw) && ovl(m_y, bw, ly, pl);
        rh = (m_dir == 0) && (nx + bw >= rx) && ovl(m_y, bw, ry, pl);
        if (lh) begin
          x = lx + pw; dir = 0;
          dy = spin_dy(m_y, bw, ly, pl); vd = spin_up(m_y, bw, ly, pl);
        end else if (rh) begin
          x = rx - bw; dir = 1;
          dy = spin_dy(m_y, bw, ry, pl); vd = spin_up(m_y, bw, ry, pl);
        end else if (m_dir == 1 && nx < 0) begin
          x = 0; dir = 1; sr = 1; ph = 2;
        end else if (m_dir == 0 && nx + bw > SW) begin
          x = SW - bw; dir = 0; sl = 1; ph = 2;
        end else x = nx;
      end else begin
        x = (SW - bw) / 2; y = (SH - bw) / 2; dy = 1; cnt = 0; ph = 0;
      end
      m_x <= x; m_y <= y; m_dir <= dir; m_vd <= vd; m_dy <= dy; m_ph <= ph;
      m_cnt <= cnt; m_sl <= sl; m_sr <= sr; m_ip <= (ph == 1) ? 1 : 0;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ball_x", int'(ball_x), m_x);
      chk("ball_y", int'(ball_y), m_y);
      chk("ball_direction", int'(ball_direction), m_dir);
      chk("in_play", int'(in_play), m_ip);
      chk("score_left", int'(score_left), m_sl);
      chk("score_right", int'(score_right), m_sr);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    cyc += n;
    #2;
  endtask

  task automatic tick_to(input int e);
    if (e > cyc) step(e - cyc);
  endtask

  task automatic pin_reset_state(input string tag);
    chk({tag, "_x"}, int'(ball_x), 317);
    chk({tag, "_y"}, int'(ball_y), 237);
    chk({tag, "_dir"}, int'(ball_direction), 1);
    chk({tag, "_in_play"}, int'(in_play), 0);
    chk({tag, "_score_left"}, int'(score_left), 0);
    chk({tag, "_score_right"}, int'(score_right), 0);
  endtask

  initial begin : stim
    int guard;
    #1 reset = 1'b1;
    #1 pin_reset_state("reset");
    chk_en = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0; enable = 1'b1; cyc = 0;

    // Serve: held at centre for 60 clocks, then one step of 4 left and 1 down per clock.
    tick_to(59);
    chk("serve_hold_in_play", int'(in_play), 0);
    chk("serve_hold_x", int'(ball_x), 317);
    tick_to(60);
    chk("serve_go_in_play", int'(in_play), 1);
    chk("serve_go_x", int'(ball_x), 317);
    chk("serve_go_y", int'(ball_y), 237);
    tick_to(61);
    chk("first_step_x", int'(ball_x), 313);
    chk("first_step_y", int'(ball_y), 238);

    // Left paddle centre hit (offset 40 of 80): inner half, heading down.
    tick_to(137);
    chk("lhit_x", int'(ball_x), 10);
    chk("lhit_y", int'(ball_y), 314);
    chk("lhit_dir", int'(ball_direction), 0);
    tick_to(138);
    chk("lhit_next_x", int'(ball_x), 14);
    chk("lhit_next_y", int'(ball_y), 315);

    // Bottom bounce on the way, then right paddle hit at offset 5: steep spin upward.
    tick_to(291);
    chk("rhit_x", int'(ball_x), 624);
    chk("rhit_y", int'(ball_y), 461);
    chk("rhit_dir", int'(ball_direction), 1);
    right_y = 9'd0;
    tick_to(292);
    chk("spin_next_x", int'(ball_x), 620);
    chk("spin_next_y", int'(ball_y), 458);

    // Top wall clamp at 10 then reflect with dy 3.
    tick_to(441);
    chk("pre_wall_y", int'(ball_y), 11);
    tick_to(442);
    chk("wall_y", int'(ball_y), 10);
    chk("wall_x", int'(ball_x), 20);
    tick_to(443);
    chk("post_wall_y", int'(ball_y), 13);
    chk("post_wall_x", int'(ball_x), 16);

    // Left miss: one-clock score_right, then recentre serving toward the left.
    tick_to(448);
    chk("lmiss_x", int'(ball_x), 0);
    chk("lmiss_score_right", int'(score_right), 1);
    chk("lmiss_score_left", int'(score_left), 0);
    chk("lmiss_in_play", int'(in_play), 0);
    tick_to(449);
    chk("rec1_x", int'(ball_x), 317);
    chk("rec1_y", int'(ball_y), 237);
    chk("rec1_dir", int'(ball_direction), 1);
    chk("rec1_score_right", int'(score_right), 0);

    // Same rally, but right paddle is out of reach: right miss, score_left.
    tick_to(743);
    chk("rmiss_x", int'(ball_x), 634);
    chk("rmiss_score_left", int'(score_left), 1);
    chk("rmiss_score_right", int'(score_right), 0);
    paddle_length = 9'd480; left_y = 9'd470; right_y = 9'd0;
    tick_to(744);
    chk("rec2_x", int'(ball_x), 317);
    chk("rec2_y", int'(ball_y), 237);
    chk("rec2_dir", int'(ball_direction), 0);
    chk("rec2_score_left", int'(score_left), 0);

    // Third rally: pause mid-play, then wait for the left miss and reset inside the pulse.
    tick_to(814);
    enable = 1'b0;
    step(5);
    enable = 1'b1;
    guard = 0;
    while (m_sr == 0 && guard < 3000) begin
      step(1);
      guard++;
    end
    if (m_sr == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_score_right: got 0 expected 1 within 3000 clocks");
    end else begin
      chk("pulse_before_reset", int'(score_right), 1);
      reset = 1'b1;
      #1 pin_reset_state("mid_scored_reset");
    end
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(70);
    chk("after_reset_in_play", int'(in_play), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
